// File: rtl/sdram_device_responder.sv
// SDRAM device model answering the pin-level command stream from the controller.
// Tracks open rows per bank, stores data in an aliased array and replays reads at CAS latency.
module sdram_device_responder #(
  parameter int unsigned ROW_BITS = 13,
  parameter int unsigned COL_BITS = 10,
  parameter int unsigned ROW_KEEP = 2,
  parameter int unsigned COL_KEEP = 8,
  parameter int unsigned TRCD     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] sd_a,
  input  logic [1:0]  sd_bs,
  input  logic        sd_cs_n,
  input  logic        sd_ras_n,
  input  logic        sd_cas_n,
  input  logic        sd_we_n,
  input  logic [1:0]  sd_dqm,
  input  logic        sd_cke,
  input  logic [15:0] sd_dout,
  input  logic        sd_dout_en,
  output logic [15:0] sd_din,
  output logic        sd_din_valid,
  output logic        mode_set,
  output logic [12:0] mode_reg,
  output logic [15:0] ref_cnt,
  output logic [5:0]  err
);

  localparam int unsigned RowKeep = (ROW_KEEP < ROW_BITS) ? ROW_KEEP : ROW_BITS;
  localparam int unsigned ColKeep = (COL_KEEP < COL_BITS) ? COL_KEEP : COL_BITS;
  localparam int unsigned AddrW   = 2 + RowKeep + ColKeep;
  localparam int unsigned Words   = 1 << AddrW;
  localparam int unsigned TrcdW   = $clog2(TRCD + 1);
  localparam logic [TrcdW-1:0] TrcdLoad = TrcdW'(TRCD - 1);

  localparam logic [2:0] CmdMrs  = 3'b000;
  localparam logic [2:0] CmdRef  = 3'b001;
  localparam logic [2:0] CmdPre  = 3'b010;
  localparam logic [2:0] CmdAct  = 3'b011;
  localparam logic [2:0] CmdWr   = 3'b100;
  localparam logic [2:0] CmdRd   = 3'b101;
  localparam logic [2:0] CmdBst  = 3'b110;
  localparam logic [2:0] CmdNop  = 3'b111;

  typedef enum logic [1:0] {StIdle, StWait, StBurst} rd_state_e;

  rd_state_e rd_state_q, rd_state_d;
  logic [3:0]                bank_open_q, bank_open_d;
  logic [3:0][RowKeep-1:0]   open_row_q, open_row_d;
  logic [3:0][TrcdW-1:0]     trcd_q, trcd_d;
  logic [12:0]               mode_reg_q, mode_reg_d;
  logic                      mode_set_q, mode_set_d;
  logic [15:0]               ref_cnt_q, ref_cnt_d;
  logic [5:0]                err_q, err_d;
  logic [15:0]               din_q, din_d;
  logic                      din_valid_q, din_valid_d;
  logic [1:0]                rd_bank_q, rd_bank_d;
  logic [RowKeep-1:0]        rd_row_q, rd_row_d;
  logic [ColKeep-1:0]        rd_col_q, rd_col_d;
  logic [2:0]                rd_k_q, rd_k_d;
  logic [2:0]                rd_last_q, rd_last_d;
  logic [15:0]               rd_mask_q, rd_mask_d;

  logic [15:0]        mem [Words];
  logic               mem_we;
  logic [1:0]         mem_be;
  logic [AddrW-1:0]   wr_addr, rd_addr;
  logic [ColKeep-1:0] last_ext, rd_col_cur;
  logic [15:0]        rd_word;
  logic [2:0]         cmd;
  logic               mode_ok, eff_cl3;
  logic [3:0]         bl_len;
  logic [2:0]         eff_last;

  function automatic logic mode_supported(input logic [12:0] w);
    return ((w[6:4] == 3'd2) || (w[6:4] == 3'd3)) && !w[3] && !w[2];
  endfunction

  // Unsupported mode words fall back to CL2 / BL1.
  assign mode_ok  = mode_supported(mode_reg_q);
  assign eff_cl3  = mode_ok && (mode_reg_q[6:4] == 3'd3);
  assign bl_len   = 4'd1 << mode_reg_q[1:0];
  assign eff_last = mode_ok ? 3'(bl_len - 4'd1) : 3'd0;

  // Sequential burst wraps inside the BL-aligned column block.
  assign last_ext   = ColKeep'(rd_last_q);
  assign rd_col_cur = (rd_col_q & ~last_ext) | ((rd_col_q + ColKeep'(rd_k_q)) & last_ext);
  assign rd_addr    = {rd_bank_q, rd_row_q, rd_col_cur};
  assign rd_word    = mem[rd_addr];
  assign wr_addr    = {sd_bs, open_row_q[sd_bs], sd_a[ColKeep-1:0]};
  assign mem_be     = ~sd_dqm;

  always_comb begin
    cmd         = sd_cs_n ? CmdNop : {sd_ras_n, sd_cas_n, sd_we_n};
    rd_state_d  = rd_state_q;
    bank_open_d = bank_open_q;
    open_row_d  = open_row_q;
    trcd_d      = trcd_q;
    mode_reg_d  = mode_reg_q;
    mode_set_d  = mode_set_q;
    ref_cnt_d   = ref_cnt_q;
    err_d       = err_q;
    din_d       = '0;
    din_valid_d = 1'b0;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    rd_k_d      = rd_k_q;
    rd_last_d   = rd_last_q;
    rd_mask_d   = rd_mask_q;
    mem_we      = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if (trcd_q[b] != '0) trcd_d[b] = trcd_q[b] - TrcdW'(1);
    end

    case (rd_state_q)
      StWait: rd_state_d = StBurst;
      StBurst: begin
        din_d       = rd_word & rd_mask_q;
        din_valid_d = 1'b1;
        if (rd_k_q == rd_last_q) rd_state_d = StIdle;
        else                     rd_k_d     = rd_k_q + 3'd1;
      end
      default: ;
    endcase

    case (cmd)
      CmdAct: begin
        if (!mode_set_q) err_d[0] = 1'b1;
        if (bank_open_q[sd_bs]) err_d[1] = 1'b1;
        bank_open_d[sd_bs] = 1'b1;
        open_row_d[sd_bs]  = sd_a[RowKeep-1:0];
        trcd_d[sd_bs]      = TrcdLoad;
      end
      CmdPre: begin
        if (sd_a[10]) bank_open_d = '0;
        else          bank_open_d[sd_bs] = 1'b0;
      end
      CmdMrs: begin
        mode_reg_d = sd_a;
        mode_set_d = 1'b1;
        if (!mode_supported(sd_a)) err_d[4] = 1'b1;
      end
      CmdRd, CmdWr: begin
        // Any column command cuts off the burst in flight.
        rd_state_d  = StIdle;
        din_d       = '0;
        din_valid_d = 1'b0;
        if (!mode_set_q) err_d[0] = 1'b1;
        if (trcd_q[sd_bs] != '0) err_d[3] = 1'b1;
        if ((cmd == CmdWr) && !sd_dout_en) err_d[5] = 1'b1;
        if (!bank_open_q[sd_bs]) begin
          err_d[2] = 1'b1;
        end else begin
          if (sd_a[10]) bank_open_d[sd_bs] = 1'b0;
          if (cmd == CmdWr) begin
            mem_we = 1'b1;
          end else begin
            rd_state_d = eff_cl3 ? StWait : StBurst;
            rd_bank_d  = sd_bs;
            rd_row_d   = open_row_q[sd_bs];
            rd_col_d   = sd_a[ColKeep-1:0];
            rd_k_d     = 3'd0;
            rd_last_d  = eff_last;
            rd_mask_d  = {{8{~sd_dqm[1]}}, {8{~sd_dqm[0]}}};
          end
        end
      end
      CmdRef: begin
        if (!mode_set_q) err_d[0] = 1'b1;
        if (bank_open_q != '0) err_d[5] = 1'b1;
        ref_cnt_d = ref_cnt_q + 16'd1;
      end
      CmdBst: begin
        rd_state_d  = StIdle;
        din_d       = '0;
        din_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q  <= StIdle;
      bank_open_q <= '0;
      open_row_q  <= '0;
      trcd_q      <= '0;
      mode_reg_q  <= '0;
      mode_set_q  <= 1'b0;
      ref_cnt_q   <= '0;
      err_q       <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      rd_bank_q   <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      rd_k_q      <= '0;
      rd_last_q   <= '0;
      rd_mask_q   <= '0;
    end else if (sd_cke) begin
      rd_state_q  <= rd_state_d;
      bank_open_q <= bank_open_d;
      open_row_q  <= open_row_d;
      trcd_q      <= trcd_d;
      mode_reg_q  <= mode_reg_d;
      mode_set_q  <= mode_set_d;
      ref_cnt_q   <= ref_cnt_d;
      err_q       <= err_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      rd_bank_q   <= rd_bank_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      rd_k_q      <= rd_k_d;
      rd_last_q   <= rd_last_d;
      rd_mask_q   <= rd_mask_d;
    end
  end

  // Storage survives reset.
  always_ff @(posedge clk) begin
    if (mem_we && sd_cke && rst_n) begin
      if (mem_be[0]) mem[wr_addr][7:0]  <= sd_dout[7:0];
      if (mem_be[1]) mem[wr_addr][15:8] <= sd_dout[15:8];
    end
  end

  assign sd_din       = din_q;
  assign sd_din_valid = din_valid_q;
  assign mode_set     = mode_set_q;
  assign mode_reg     = mode_reg_q;
  assign ref_cnt      = ref_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Scoreboard bench: a transaction-level SDRAM model predicts read words per clock edge,
// a monitor compares whatever the device presents.
module tb_sdram_device_responder;

  localparam int TRCD = 2;
  localparam logic [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
  localparam logic [2:0] WR  = 3'b100, RD  = 3'b101, BST = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_cke, sd_dout_en;
  logic [12:0] sd_a;
  logic [1:0]  sd_bs, sd_dqm;
  logic [15:0] sd_dout, sd_din, ref_cnt;
  logic        sd_din_valid, mode_set;
  logic [12:0] mode_reg;
  logic [5:0]  err;

  always #5 clk = ~clk;

  sdram_device_responder dut (
    .clk(clk), .rst_n(rst_n), .sd_a(sd_a), .sd_bs(sd_bs), .sd_cs_n(sd_cs_n),
    .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n), .sd_we_n(sd_we_n), .sd_dqm(sd_dqm),
    .sd_cke(sd_cke), .sd_dout(sd_dout), .sd_dout_en(sd_dout_en), .sd_din(sd_din),
    .sd_din_valid(sd_din_valid), .mode_set(mode_set), .mode_reg(mode_reg),
    .ref_cnt(ref_cnt), .err(err)
  );

  typedef struct {
    int          e;  // edge at which the word is registered
    logic [15:0] d;
    logic [15:0] m;  // bits whose value is known
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model state
  logic [15:0] mmem   [4096];
  logic [1:0]  mknown [4096];
  bit          mopen  [4];
  int          mrow   [4];
  int          mact   [4];
  logic [12:0] mreg;
  bit          mset;
  logic [5:0]  merr;
  int          mref;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void truncate(input int from);
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].e >= from) sb.delete(i);
  endfunction

  function automatic bit ok_mode(input logic [12:0] w);
    return (w[6:4] == 3'd2 || w[6:4] == 3'd3) && !w[3] && (w[2:0] <= 3'd3);
  endfunction

  function automatic void model_reset(input int n);
    for (int b = 0; b < 4; b++) begin
      mopen[b] = 0;
      mact[b]  = -100;
    end
    mreg = '0; mset = 0; merr = '0; mref = 0;
    truncate(n);
  endfunction

  function automatic void model_cmd(input int n, input logic [2:0] c, input logic [1:0] bs,
                                    input logic [12:0] a, input logic [1:0] dqm,
                                    input logic [15:0] dout, input logic den);
    int cl, bl, col, base, cc, idx, b;
    logic [15:0] dm, km;
    exp_t ex;
    b  = int'(bs);
    cl = ok_mode(mreg) ? int'(mreg[6:4]) : 2;
    bl = ok_mode(mreg) ? (1 << mreg[2:0]) : 1;
    case (c)
      ACT: begin
        if (!mset) merr[0] = 1'b1;
        if (mopen[b]) merr[1] = 1'b1;
        mopen[b] = 1; mrow[b] = int'(a); mact[b] = n;
      end
      PRE: begin
        if (a[10]) for (int i = 0; i < 4; i++) mopen[i] = 0;
        else mopen[b] = 0;
      end
      MRS: begin
        mreg = a; mset = 1;
        if (!ok_mode(a)) merr[4] = 1'b1;
      end
      RD, WR: begin
        truncate(n);
        if (!mset) merr[0] = 1'b1;
        if (n - mact[b] < TRCD) merr[3] = 1'b1;
        if (c == WR && !den) merr[5] = 1'b1;
        if (!mopen[b]) begin
          merr[2] = 1'b1;
        end else begin
          col = int'(a[9:0]);
          if (c == WR) begin
            idx = b * 1024 + (mrow[b] % 4) * 256 + col % 256;
            if (!dqm[0]) begin mmem[idx][7:0]  = dout[7:0];  mknown[idx][0] = 1'b1; end
            if (!dqm[1]) begin mmem[idx][15:8] = dout[15:8]; mknown[idx][1] = 1'b1; end
          end else begin
            dm   = {{8{~dqm[1]}}, {8{~dqm[0]}}};
            base = col - col % bl;
            for (int k = 0; k < bl; k++) begin
              cc   = base + (col + k) % bl;
              idx  = b * 1024 + (mrow[b] % 4) * 256 + cc % 256;
              km   = {{8{mknown[idx][1]}}, {8{mknown[idx][0]}}};
              ex.e = n + cl - 1 + k;
              ex.d = mmem[idx] & dm;
              ex.m = km | ~dm;
              sb.push_back(ex);
            end
          end
          if (a[10]) mopen[b] = 0;
        end
      end
      REF: begin
        if (!mset) merr[0] = 1'b1;
        if (mopen[0] || mopen[1] || mopen[2] || mopen[3]) merr[5] = 1'b1;
        mref = (mref + 1) % 65536;
      end
      BST: truncate(n);
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] c, input logic [1:0] bs, input logic [12:0] a,
                       input logic [1:0] dqm = 2'b00, input logic [15:0] dout = 16'h0,
                       input logic den = 1'b1);
    sd_cs_n = 1'b0;
    {sd_ras_n, sd_cas_n, sd_we_n} = c;
    sd_bs = bs; sd_a = a; sd_dqm = dqm; sd_dout = dout; sd_dout_en = den;
    model_cmd(edge_n + 1, c, bs, a, dqm, dout, den);
    @(posedge clk); #1;
    sd_cs_n = 1'b1; sd_dout_en = 1'b0; sd_dqm = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sd_cs_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; sd_cs_n = 1'b1;
    model_reset(edge_n + 1);
    repeat (cycles) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic boot(input logic [12:0] mode);
    issue(PRE, 2'd0, 13'h400);
    issue(MRS, 2'd0, mode);
    idle(1);
    repeat (8) begin issue(REF, 2'd0, 13'h0); idle(1); end
  endtask

  task automatic rand_cmd();
    int r;
    logic [1:0] bs;
    logic [12:0] a;
    r  = $urandom_range(0, 99);
    bs = 2'($urandom_range(0, 3));
    a  = 13'($urandom_range(0, 8191));
    if (r < 14) begin
      issue(ACT, bs, a);
    end else if (r < 22) begin
      a[10] = ($urandom_range(0, 3) == 0);
      issue(PRE, bs, a);
    end else if (r < 88) begin
      a[9:0] = 10'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      a[10]  = ($urandom_range(0, 7) == 0);
      if (r < 52)
        issue(WR, bs, a, 2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 15) != 0);
      else if (r < 82)
        issue(RD, bs, a, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
      else
        issue(BST, bs, a);
    end else if (r < 91) begin
      issue(REF, bs, a);
    end else begin
      idle(1);
    end
  endtask

  // Monitor: every cycle, the device output must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t ex;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].e < edge_n) begin
        n_checks++; n_fail++;
        $display("FAIL rd_missing: no valid word at edge %0d, required 0x%h", sb[0].e, sb[0].d);
        void'(sb.pop_front());
      end
      n_checks++;
      if (sd_din_valid === 1'b1) begin
        if (sb.size() == 0 || sb[0].e != edge_n) begin
          n_fail++;
          $display("FAIL rd_unexpected: valid word 0x%h at edge %0d, none required", sd_din, edge_n);
        end else begin
          ex = sb.pop_front();
          if ((sd_din & ex.m) !== (ex.d & ex.m)) begin
            n_fail++;
            $display("FAIL rd_data: edge %0d got 0x%h required 0x%h (mask 0x%h)",
                     edge_n, sd_din, ex.d, ex.m);
          end
        end
      end else if (sd_din_valid !== 1'b0 || sd_din !== 16'h0) begin
        n_fail++;
        $display("FAIL rd_idle: edge %0d valid=%b din=0x%h, required 0/0x0000",
                 edge_n, sd_din_valid, sd_din);
      end
    end
  end

  logic [15:0] modes [4] = '{16'h033, 16'h021, 16'h032, 16'h020};

  initial begin
    rst_n = 1'b0; sd_cke = 1'b1; sd_cs_n = 1'b1;
    {sd_ras_n, sd_cas_n, sd_we_n} = 3'b111;
    sd_a = '0; sd_bs = '0; sd_dqm = '0; sd_dout = '0; sd_dout_en = 1'b0;
    for (int i = 0; i < 4096; i++) mknown[i] = 2'b00;

    do_reset(3);
    check("reset_din", sd_din, 0);
    check("reset_valid", sd_din_valid, 0);
    check("reset_mode_set", mode_set, 0);
    check("reset_mode_reg", mode_reg, 0);
    check("reset_ref_cnt", ref_cnt, 0);
    check("reset_err", err, 0);
    mon_en = 1;

    boot(13'h020);
    check("boot_mode_set", mode_set, 1);
    check("boot_mode_reg", mode_reg, 13'h020);
    check("boot_ref_cnt", ref_cnt, 8);
    check("boot_err", err, 0);

    // CL2 single access and byte masks
    issue(ACT, 2'd0, 13'd5);
    idle(1);
    issue(WR, 2'd0, 13'h012, 2'b00, 16'hA55A);
    issue(RD, 2'd0, 13'h012);
    idle(3);
    issue(WR, 2'd0, 13'h012, 2'b10, 16'h1234);
    issue(RD, 2'd0, 13'h012);
    idle(2);
    issue(RD, 2'd0, 13'h012, 2'b01);
    idle(3);

    // BL4 wrap, then burst stop after two words
    issue(MRS, 2'd0, 13'h022);
    idle(1);
    for (int k = 4; k < 8; k++) issue(WR, 2'd0, 13'(k), 2'b00, 16'(k));
    issue(RD, 2'd0, 13'd6);
    idle(5);
    issue(RD, 2'd0, 13'd6);
    idle(2);
    issue(BST, 2'd0, 13'd0);
    idle(4);

    // Protocol errors
    check("pre_err", err, 0);
    issue(ACT, 2'd1, 13'd7);
    idle(2);
    issue(ACT, 2'd1, 13'd7);
    check("err_act_open", err, 6'h02);
    issue(PRE, 2'd1, 13'd0);
    issue(ACT, 2'd1, 13'd7);
    issue(RD, 2'd1, 13'd0);
    check("err_trcd", err, 6'h0A);
    issue(REF, 2'd0, 13'd0);
    check("err_ref_open", err, 6'h2A);
    issue(RD, 2'd2, 13'd0);
    check("err_rd_idle", err, 6'h2E);
    idle(3);
    issue(MRS, 2'd0, 13'h050);
    check("err_bad_mode", err, 6'h3E);
    issue(RD, 2'd0, 13'h012);
    idle(3);
    issue(MRS, 2'd0, 13'h033);
    idle(1);
    issue(RD, 2'd0, 13'h004);
    idle(12);

    // Reset in the middle of a BL8 burst
    issue(MRS, 2'd0, 13'h023);
    idle(1);
    issue(RD, 2'd0, 13'h004);
    idle(2);
    do_reset(1);
    check("midrst_valid", sd_din_valid, 0);
    check("midrst_err", err, 0);
    check("midrst_mode_set", mode_set, 0);
    check("midrst_ref_cnt", ref_cnt, 0);
    boot(13'h020);
    check("reboot_ref_cnt", ref_cnt, 8);

    // Clock enable low ignores the command
    sd_cke = 1'b0; sd_cs_n = 1'b0;
    {sd_ras_n, sd_cas_n, sd_we_n} = REF;
    @(posedge clk); #1;
    sd_cke = 1'b1; sd_cs_n = 1'b1;
    check("cke_ref_cnt", ref_cnt, 8);

    issue(ACT, 2'd0, 13'd5);
    idle(1);
    issue(RD, 2'd0, 13'h012);
    idle(1);
    issue(RD, 2'd0, 13'd6);
    idle(3);
    check("reinit_err", err, 0);

    // Randomised traffic per mode
    for (int p = 0; p < 4; p++) begin
      issue(PRE, 2'd0, 13'h400);
      issue(MRS, 2'd0, modes[p][12:0]);
      idle(1);
      repeat (250) rand_cmd();
      idle(12);
      check("rand_err", err, merr);
      check("rand_ref_cnt", ref_cnt, mref);
      check("rand_mode_reg", mode_reg, mreg);
    end

    idle(15);
    check("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
